rr_fixed_arb: RTL

Parametrised N-requester arbiter with run-time selectable fixed-priority or round-robin policy, registered one-hot grant, and a bounded grant-hold (burst) limit. It is the generalised successor to the team's 3-input fixed-priority arbiter. It sits in front of any shared resource (bus port, memory bank, FIFO write side) where requesters need either strict priority or fairness, plus a cap on how long a single requester may hold the resource.

---
 rtl/rr_fixed_arb.sv | 94 +++++++++
 1 files changed

// File: rtl/rr_fixed_arb.sv
// N-requester arbiter with run-time fixed-priority / round-robin policy,
// registered one-hot grant and a bounded grant-hold (burst) limit.
module rr_fixed_arb #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic                 mode,
  output logic [N-1:0]         gnt,
  output logic                 gnt_vld,
  output logic [$clog2(N)-1:0] gnt_id
);

  localparam int IW = $clog2(N);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [IW-1:0] PTR_RST   = IW'(N - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e        state;
  logic [HW-1:0] hold_cnt, hold_cnt_nxt;
  logic [IW-1:0] rr_ptr, rr_ptr_nxt;
  logic [N-1:0]  gnt_nxt;
  logic [IW-1:0] fp_idx, hi_idx, rr_idx, win_idx;
  logic          hi_found;
  logic          holder_req;

  // Outputs are decoded from the grant register only, so no req->output path.
  assign gnt_vld    = |gnt;
  assign state      = gnt_vld ? BUSY : IDLE;
  assign holder_req = |(req & gnt);

  always_comb begin
    gnt_id = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) gnt_id = gnt_id | IW'(i);
    end
  end

  // Lowest set bit overall, and lowest set bit strictly above rr_ptr.
  // Round-robin takes the latter if it exists, otherwise wraps to the former,
  // which is exact for non-power-of-2 N.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    fp_idx   = '0;
    hi_idx   = '0;
    hi_found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) fp_idx = IW'(i);
      if (req[i] && (IW'(i) > rr_ptr)) begin
        hi_idx   = IW'(i);
        hi_found = 1'b1;
      end
    end
    rr_idx  = hi_found ? hi_idx : fp_idx;
    win_idx = mode ? rr_idx : fp_idx;
  end

  always_comb begin
    gnt_nxt      = gnt;
    hold_cnt_nxt = hold_cnt;
    rr_ptr_nxt   = rr_ptr;
    if (state == BUSY && holder_req && hold_cnt < HOLD_LAST) begin
      hold_cnt_nxt = hold_cnt + HW'(1);
    end else if (|req) begin
      gnt_nxt      = N'(1) << win_idx;
      hold_cnt_nxt = '0;
      rr_ptr_nxt   = win_idx;
    end else begin
      gnt_nxt      = '0;
      hold_cnt_nxt = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt      <= '0;
      hold_cnt <= '0;
      rr_ptr   <= PTR_RST;
    end else begin
      gnt      <= gnt_nxt;
      hold_cnt <= hold_cnt_nxt;
      rr_ptr   <= rr_ptr_nxt;
    end
  end

endmodule
